mdu_hilo: RTL and testbench
===========================

# mdu_hilo

Parametrised multiply/divide unit with architectural HI/LO registers, sitting in the E stage beside the ALU. It executes the mult/div/move-to/move-from group flagged by the decoder's `ISMULTDIV` and `MULTSel` outputs. Operation latency is configurable, and a busy/stall handshake lets the hazard unit freeze D-stage MD instructions. It generalises the fixed 32-bit, fixed-latency MD path to parametric width and latency, optionally with accumulate ops.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for mult class (≥1).
- `DIV_CYCLES`, 10: busy cycles for div class (≥1).
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  an MD instruction is in E this cycle, not stalled or flushed.
- `op`  in  4  `{ext, MULTSel}`. Encodings:
  - 0000 mfhi, 0001 mthi, 0010 mflo, 0011 mtlo
  - 0100 mult, 0101 multu, 0110 div, 0111 divu
  - 1100 madd, 1101 maddu, 1110 msub, 1111 msubu
- `rs_val`, `rt_val`  in  WIDTH  forwarded E-stage operands.
- `busy`  out  1  registered; a multi-cycle op is in flight.
- `stall_md`  out  1  `busy | (start & op[2])`. The hazard unit stalls a D-stage `ISMULTDIV` instruction while this is high.
- `rd_val`  out  WIDTH  combinational: HI when `op[1]==0`, else LO. Used by mfhi/mflo.
- `hi`, `lo`  out  WIDTH  registered architectural HI/LO.

## Operation
- Reset, asynchronous: `hi`=0, `lo`=0, `busy`=0, counter=0, pending result=0.
- States:
  - IDLE (counter 0)
  - RUN (counter >0)
- IDLE with `start`:
  - mult class or div class (`op[2]`=1): compute the result from the operands, latch it into pending HI/LO, load counter with the class latency, go to RUN.
  - mthi/mtlo: write `rs_val` to HI or LO at the same edge; no busy.
  - mfhi/mflo: no state change.
- RUN: counter decrements each cycle. At the edge where it reaches 0, pending HI/LO commit and `busy` falls.
- `start` while in RUN: ignored, including mt*. This is a protocol violation the hazard unit prevents.
- mult/multu: 2·WIDTH-bit product, signed or unsigned. HI = upper half, LO = lower half.
- div/divu:
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - Signed MIN/−1: LO = MIN, HI = 0.
  - Divisor 0: HI/LO keep their values, but the op still takes DIV_CYCLES busy cycles.
- madd/msub class: {HI,LO} ± product, modulo 2^(2·WIDTH). The operation uses HI/LO as they stand at the start edge and takes MULT_CYCLES.
- Reset mid-operation: the in-flight op is discarded; all state returns to reset values.

## Timing
- `start` is sampled at edge t0; `busy` is high for cycles t0+1 … t0+N. HI/LO take the new values at edge t0+N, and `busy` is low from that edge.
- An mfhi issued in the first cycle with `busy`=0 reads the new value (zero-bubble handoff).
- mthi/mtlo: HI/LO are updated at the next edge; an mfhi in the following cycle sees the new value.
- `stall_md` is combinational from `start`/`op` and registered `busy`; there is no combinational path from `rs_val`/`rt_val`.
- Counter width: `$clog2(max(MULT_CYCLES,DIV_CYCLES)+1)`.

## Configuration
- `MDU_MADD_EN` defined: opcodes 1100–1111 execute as accumulate ops as specified above.
- `MDU_MADD_EN` undefined:
  - `op[3]`=1 with `start` is a no-op: no busy, no HI/LO change.
  - `stall_md` ignores these ops.
  - The accumulate adder is not synthesised.

## Structure
- Package `mdu_pkg` holds:
  - the 4-bit op encodings as localparams (`MD_MFHI` … `MD_MSUBU`)
  - the class predicates (is_mult, is_div, is_acc, is_move)
- One sub-module, `mdu_latency_ctr`:
  - loadable down-counter, parametrised by width
  - ports `load`, `load_val`, `busy`, `done_pulse`
  - the top level commits pending HI/LO on `done_pulse`

## Test plan
- mult 0xFFFFFFFF × 0x00000002 → after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE. `busy` is high for exactly 5 cycles.
- div −7 / 2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi 0x1234, then divu 7 / 0 → HI stays 0x1234, LO is unchanged, and `busy` is high for 10 cycles.
- start mult, then assert `start` with mtlo 0xAA during RUN → the mtlo is ignored, and LO takes the product at completion. `stall_md` is high from the mult start cycle through the last busy cycle.
- With `MDU_MADD_EN`: HI=0, LO=5, madd 3,4 → LO=17, HI=0. Without the macro: the same stimulus leaves LO=5, and `busy` stays 0.
- Assert `reset_n` low at cycle 3 of a div → `busy`, HI and LO are 0 immediately. After release, mflo returns 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// ----------------------------------------------------------------------
// mdu_pkg: MD op encodings and class predicates shared by the MDU.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  localparam logic [3:0] MD_MFHI  = 4'b0000;
  localparam logic [3:0] MD_MTHI  = 4'b0001;
  localparam logic [3:0] MD_MFLO  = 4'b0010;
  localparam logic [3:0] MD_MTLO  = 4'b0011;
  localparam logic [3:0] MD_MULT  = 4'b0100;
  localparam logic [3:0] MD_MULTU = 4'b0101;
  localparam logic [3:0] MD_DIV   = 4'b0110;
  localparam logic [3:0] MD_DIVU  = 4'b0111;
  localparam logic [3:0] MD_MADD  = 4'b1100;
  localparam logic [3:0] MD_MADDU = 4'b1101;
  localparam logic [3:0] MD_MSUB  = 4'b1110;
  localparam logic [3:0] MD_MSUBU = 4'b1111;

  function automatic logic is_mult(input logic [3:0] op);
    return op[3:1] == 3'b010;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op[3:1] == 3'b011;
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic is_move(input logic [3:0] op);
    return op[3:2] == 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_latency_ctr.sv
// ----------------------------------------------------------------------
// mdu_latency_ctr: loadable down-counter timing the MDU busy window.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module mdu_latency_ctr #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy,
  output logic          done_pulse
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      cnt_d  = load_val;
      busy_d = (load_val != '0);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - 1'b1;
      busy_d = (cnt_q != CW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
  // High during the last busy cycle, so the commit lands on the edge busy falls
  assign done_pulse = busy_q & (cnt_q == CW'(1));

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// ----------------------------------------------------------------------
// mdu_hilo: multiply/divide unit with HI/LO; MDU_MADD_EN enables madd/msub.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             stall_md,
  output logic [WIDTH-1:0] rd_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int W2         = 2 * WIDTH;

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             ctr_load;
  logic [CW-1:0]    ctr_load_val;
  logic             done_pulse;
  logic             accept;
  logic             md_class;

  logic [W2-1:0]    op_a_ext, op_b_ext, product;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b, div_b, quot_mag, rem_mag, quot, rem;

  // op[0] selects unsigned for every multiply/divide flavour
  always_comb begin
    if (op[0]) begin
      op_a_ext = {{WIDTH{1'b0}}, rs_val};
      op_b_ext = {{WIDTH{1'b0}}, rt_val};
    end else begin
      op_a_ext = {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
      op_b_ext = {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
    end
    product = op_a_ext * op_b_ext;
  end

  // Sign-magnitude divide; MIN/-1 falls out as quotient MIN, remainder 0
  always_comb begin
    neg_a    = ~op[0] & rs_val[WIDTH-1];
    neg_b    = ~op[0] & rt_val[WIDTH-1];
    abs_a    = neg_a ? -rs_val : rs_val;
    abs_b    = neg_b ? -rt_val : rt_val;
    div_b    = (abs_b == '0) ? WIDTH'(1) : abs_b;
    quot_mag = abs_a / div_b;
    rem_mag  = abs_a % div_b;
    quot     = (neg_a ^ neg_b) ? -quot_mag : quot_mag;
    rem      = neg_a ? -rem_mag : rem_mag;
  end

`ifdef MDU_MADD_EN
  logic [W2-1:0] acc_sum;
  always_comb begin
    acc_sum = op[1] ? ({hi_q, lo_q} - product) : ({hi_q, lo_q} + product);
  end
  assign md_class = op[2];
`else
  assign md_class = op[2] & ~op[3];
`endif

  assign accept = start & ~busy;

  always_comb begin
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    if (done_pulse) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end else if (accept) begin
      if (is_mult(op)) begin
        {pend_hi_d, pend_lo_d} = product;
        ctr_load               = 1'b1;
        ctr_load_val           = CW'(MULT_CYCLES);
      end else if (is_div(op)) begin
        if (rt_val != '0) begin
          pend_hi_d = rem;
          pend_lo_d = quot;
        end else begin
          pend_hi_d = hi_q;
          pend_lo_d = lo_q;
        end
        ctr_load     = 1'b1;
        ctr_load_val = CW'(DIV_CYCLES);
`ifdef MDU_MADD_EN
      end else if (is_acc(op)) begin
        {pend_hi_d, pend_lo_d} = acc_sum;
        ctr_load               = 1'b1;
        ctr_load_val           = CW'(MULT_CYCLES);
`endif
      end else if (op == MD_MTHI) begin
        hi_d = rs_val;
      end else if (op == MD_MTLO) begin
        lo_d = rs_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  mdu_latency_ctr #(
    .CW(CW)
  ) u_ctr (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (ctr_load),
    .load_val  (ctr_load_val),
    .busy      (busy),
    .done_pulse(done_pulse)
  );

  assign stall_md = busy | (start & md_class);
  assign rd_val   = op[1] ? lo_q : hi_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// ----------------------------------------------------------------------
// tb_mdu_hilo: directed bench with a cycle-level reference model of the MDU.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [3:0]   op      = MD_MFLO;
  logic [W-1:0] rs_val  = '0;
  logic [W-1:0] rt_val  = '0;
  logic         busy, stall_md;
  logic [W-1:0] rd_val, hi, lo;

  always #5 clk = ~clk;

  mdu_hilo #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .stall_md(stall_md),
    .rd_val(rd_val), .hi(hi), .lo(lo)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  // Reference model: 64-bit arithmetic straight from the op definitions
  function automatic logic [63:0] mprod(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ua, ub;
    longint          sa, sb;
    if (o[0]) begin
      ua = 64'(a); ub = 64'(b);
      return ua * ub;
    end
    sa = longint'($signed(a)); sb = longint'($signed(b));
    return sa * sb;
  endfunction

  function automatic logic [63:0] mdiv(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [63:0] keep);
    longint sa, sb, q, r;
    if (b == 0) return keep;
    if (o[0]) return {a % b, a / b};
    sa = longint'($signed(a)); sb = longint'($signed(b));
    q = sa / sb; r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] macc(input logic [3:0] o, input logic [63:0] hl,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
    return o[1] ? hl - mprod(o, a, b) : hl + mprod(o, a, b);
  endfunction

  logic [W-1:0] m_hi, m_lo, m_phi, m_plo;
  int           m_left;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= '0; m_lo <= '0; m_phi <= '0; m_plo <= '0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_phi;
        m_lo <= m_plo;
      end
    end else if (start) begin
      case (op)
        MD_MTHI: m_hi <= rs_val;
        MD_MTLO: m_lo <= rs_val;
        MD_MULT, MD_MULTU: begin
          {m_phi, m_plo} <= mprod(op, rs_val, rt_val);
          m_left <= 5;
        end
        MD_DIV, MD_DIVU: begin
          {m_phi, m_plo} <= mdiv(op, rs_val, rt_val, {m_hi, m_lo});
          m_left <= 10;
        end
        MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: if (MADD) begin
          {m_phi, m_plo} <= macc(op, {m_hi, m_lo}, rs_val, rt_val);
          m_left <= 5;
        end
        default: ;
      endcase
    end
  end

  logic chk_en = 1'b0;
  logic exp_stall;

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      exp_stall = (m_left > 0) | (start & op[2] & (MADD | ~op[3]));
      check("busy", W'(busy), W'(m_left > 0));
      check("stall_md", W'(stall_md), W'(exp_stall));
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("rd_val", rd_val, op[1] ? m_lo : m_hi);
    end
  end

  // One-cycle start pulse, then count busy cycles with op parked on mflo
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output int nb);
    @(posedge clk); #2;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #2;
    start = 1'b0; op = MD_MFLO;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
  endtask

  int nb;
  logic stall_all;

  initial begin
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", W'(busy), 32'h0);

    issue(MD_MULT, 32'hFFFF_FFFF, 32'h2, nb);
    check("mult_busy_cycles", nb, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    check("mflo_handoff", rd_val, 32'hFFFF_FFFE);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2, nb);
    check("multu_hi", hi, 32'h1);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'h2, nb);
    check("div_busy_cycles", nb, 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0);

    issue(MD_MTHI, 32'h1234, 32'h0, nb);
    check("mthi_busy_cycles", nb, 32'd0);
    check("mthi_hi", hi, 32'h1234);

    issue(MD_DIVU, 32'h7, 32'h0, nb);
    check("div0_busy_cycles", nb, 32'd10);
    check("div0_hi", hi, 32'h1234);
    check("div0_lo", lo, 32'h8000_0000);

    // mtlo held on start throughout the mult's run must be ignored
    @(posedge clk); #2;
    start = 1'b1; op = MD_MULT; rs_val = 32'd3; rt_val = 32'd5;
    @(posedge clk); #2;
    op = MD_MTLO; rs_val = 32'hAA;
    nb = 0; stall_all = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      stall_all &= stall_md;
      @(posedge clk); #2;
      if (i == 2) begin start = 1'b0; op = MD_MFLO; end
    end
    check("mtlo_run_busy_cycles", nb, 32'd5);
    check("mtlo_run_stall", W'(stall_all), 32'h1);
    check("mtlo_run_lo", lo, 32'd15);
    check("mtlo_run_hi", hi, 32'h0);

    issue(MD_MTHI, 32'h0, 32'h0, nb);
    issue(MD_MTLO, 32'd5, 32'h0, nb);
    issue(MD_MADD, 32'd3, 32'd4, nb);
`ifdef MDU_MADD_EN
    check("madd_busy_cycles", nb, 32'd5);
    check("madd_lo", lo, 32'd17);
    check("madd_hi", hi, 32'h0);
    issue(MD_MSUBU, 32'd1, 32'd20, nb);
    check("msubu_lo", lo, 32'hFFFF_FFFD);
    check("msubu_hi", hi, 32'hFFFF_FFFF);
`else
    check("madd_busy_cycles", nb, 32'd0);
    check("madd_lo", lo, 32'd5);
    check("madd_hi", hi, 32'h0);
`endif

    // Reset asserted in the third busy cycle of a div
    @(posedge clk); #2;
    start = 1'b1; op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #2;
    start = 1'b0; op = MD_MFLO;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", W'(busy), 32'h0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    check("rst_mflo", rd_val, 32'h0);
    repeat (12) @(posedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
